// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, start/done handshake.
// Optional zero flag output z when SERIAL_SUB_ZERO_FLAG_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bw,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  output logic             z,
`endif
  output logic             o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sh, b_sh, d_n;
  logic [CNT_W-1:0] count;
  logic             br, br_n;
  logic             x, y, dbit;
  logic             last, accept;

  always_comb begin
    x      = a_sh[0];
    y      = b_sh[0];
    dbit   = x ^ y ^ br;
    br_n   = (~x & y) | (~(x ^ y) & br);
    d_n    = {dbit, d[WIDTH-1:1]};
    last   = (count == CNT_W'(WIDTH - 1));
    accept = start && (state != SHIFT);
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = start ? SHIFT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      count <= '0;
      d     <= '0;
      bw    <= 1'b0;
      o     <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      z     <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      br    <= 1'b0;
      count <= '0;
      d     <= '0;
      bw    <= 1'b0;
      o     <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      z     <= 1'b0;
`endif
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      br    <= br_n;
      d     <= d_n;
      count <= count + 1'b1;
      // on the last bit x/y are the operand sign bits
      if (last) begin
        bw <= br_n;
        o  <= (x ^ y) & (dbit ^ x);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        z  <= ~|d_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases plus random operands.
// Checks z as well when SERIAL_SUB_ZERO_FLAG_EN is defined.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, d;
  logic         busy, done, bw, o;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         z;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] expq[$];

  serial_subtractor #(.WIDTH(W), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bw    (bw),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    .z     (z),
`endif
    .o     (o)
  );

  always #5 clk = ~clk;

  // expected {z, o, bw, d} from plain arithmetic
  function automatic logic [6:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    logic [W-1:0] dd;
    logic ov, bo, zz;
    sd = int'($signed(x)) - int'($signed(y));
    dd = W'(x - y);
    ov = (sd > 7) || (sd < -8);
    bo = (int'(x) < int'(y));
    zz = (dd == '0);
    return {zz, ov, bo, dd};
  endfunction

  function automatic logic [6:0] got();
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    return {z, o, bw, d};
`else
    return {1'b0, o, bw, d};
`endif
  endfunction

  function automatic logic [6:0] mask(input logic [6:0] v);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    return v;
`else
    return {1'b0, v[5:0]};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expq.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [6:0] e;
        e = expq.pop_front();
        check("result", 32'(got()), 32'(mask(e)));
      end
    end
  end

  task automatic op(input logic [W-1:0] ai, input logic [W-1:0] bi);
    int cyc;
    logic [6:0] e;
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    e = model(ai, bi);
    expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cyc = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(W + 1));
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("result_hold", 32'(got()), 32'(mask(e)));
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({busy, done, d, bw, o}), 32'd0);
    rst = 1'b0;

    op(4'b0000, 4'b0000);
    op(4'b1010, 4'b0101);
    op(4'b0000, 4'b0001);
    op(4'b0111, 4'b1000);
    op(4'b1001, 4'b1001);

    // reset aborts an operation in flight
    @(negedge clk);
    a = 4'b0101;
    b = 4'b0011;
    start = 1'b1;
    expq.push_back(model(4'b0101, 4'b0011));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(expq.pop_back());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    op(4'b0101, 4'b0011);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", 32'(busy), 32'd0);

    // start while busy is ignored; held start chains a second op
    @(negedge clk);
    a = 4'b1100;
    b = 4'b0100;
    start = 1'b1;
    expq.push_back(model(4'b1100, 4'b0100));
    @(negedge clk);
    a = 4'b0000;
    b = 4'b0001;
    expq.push_back(model(4'b0000, 4'b0001));
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_second_done", 32'(done), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op(W'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
